tx_controller: RTL and testbench

Sequences frames into `tx_frontend`. It buffers bytes written by the register bank in a small FIFO and launches one frame at a time with a single-cycle `transmit` pulse. It holds a per-frame snapshot of the line configuration so the frontend never sees configuration change mid-frame, and it produces the TX status flags read back over Wishbone. It sits between the register bank and `tx_frontend`.

---
 rtl/dwbuart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 80 ++++++++
 rtl/tx_controller.sv | 187 ++++++++++++++++++
 tb/tb_tx_controller.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dwbuart_pkg.sv
// Shared types for the UART transmit path: controller state encoding and
// the per-frame line configuration bundle handed to the frontend.
package dwbuart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } tx_ctrl_state_t;

  typedef struct packed {
    logic [15:0] acc_incr;
    logic        ds;
    logic [1:0]  p;
    logic        s;
  } uart_cfg_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth. Pointers wrap naturally at
// DEPTH; occupancy carries one extra bit so full and empty never alias.
// The head entry is presented combinationally on rdata_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next pointer, occupancy and storage; flush overrides any push or pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    mem_d   = mem_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = wptr_q + PTR_ONE;
      end
      if (pop_i) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      if (push_i && !pop_i) begin
        level_d = level_q + LVL_ONE;
      end else if (!push_i && pop_i) begin
        level_d = level_q - LVL_ONE;
      end
    end
  end

  // Pointer and occupancy registers, emptied immediately on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage array needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;
  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_MAX);

endmodule

// File: rtl/tx_controller.sv
// Transmit sequencer between the register bank and tx_frontend. Buffers
// written bytes, launches one frame at a time with a one-cycle transmit
// pulse, snapshots the line configuration per frame and keeps the TX
// status flags. Define DWBUART_TX_FIFO_EN for a FIFO_DEPTH-entry buffer;
// otherwise a single holding register is used.
module tx_controller #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [15:0]                   cr_acc_incr_i,
  input  logic                          cr_ds_i,
  input  logic [1:0]                    cr_p_i,
  input  logic                          cr_s_i,
  input  logic                          cr_te_i,
  input  logic                          wr_i,
  input  logic [7:0]                    wdata_i,
  input  logic                          flush_i,
  input  logic                          tc_clr_i,
  input  logic                          ovf_clr_i,
  input  logic                          done_i,
  output logic [15:0]                   cr_acc_incr_o,
  output logic                          cr_ds_o,
  output logic [1:0]                    cr_p_o,
  output logic                          cr_s_o,
  output logic                          transmit_o,
  output logic [7:0]                    dr_o,
  output logic                          txe_o,
  output logic                          txf_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic                          tc_o,
  output logic                          ovf_o
);

  import dwbuart_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  tx_ctrl_state_t state_q, state_d;
  logic           transmit_q, transmit_d;
  logic [7:0]     dr_q, dr_d;
  uart_cfg_t      cfg_q, cfg_d;
  uart_cfg_t      cfg_in;
  logic           tc_q, tc_d;
  logic           ovf_q, ovf_d;

  logic           buf_empty;
  logic           buf_full;
  logic [7:0]     buf_head;
  logic [LW-1:0]  buf_level;
  logic           launch;
  logic           wr_accept;
  logic           ovf_set;
  logic           tc_set;

  assign cfg_in    = {cr_acc_incr_i, cr_ds_i, cr_p_i, cr_s_i};
  assign launch    = (state_q == IDLE) && cr_te_i && !buf_empty;
  assign wr_accept = wr_i && !flush_i && (!buf_full || launch);
  assign ovf_set   = wr_i && !flush_i && !wr_accept;
  assign tc_set    = (state_q == WAIT) && done_i && buf_empty && !wr_accept;

`ifdef DWBUART_TX_FIFO_EN
  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wr_accept),
    .pop_i   (launch),
    .flush_i (flush_i),
    .wdata_i (wdata_i),
    .rdata_o (buf_head),
    .level_o (buf_level),
    .empty_o (buf_empty),
    .full_o  (buf_full)
  );
`else
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;

  // Single-entry buffer: a write may refill it in the same cycle it is popped.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (flush_i) begin
      hold_valid_d = 1'b0;
    end else begin
      if (launch) begin
        hold_valid_d = 1'b0;
      end
      if (wr_accept) begin
        hold_d       = wdata_i;
        hold_valid_d = 1'b1;
      end
    end
  end

  // Holding register, emptied immediately on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign buf_head  = hold_q;
  assign buf_empty = !hold_valid_q;
  assign buf_full  = hold_valid_q;
  assign buf_level = {{(LW-1){1'b0}}, hold_valid_q};
`endif

  // Next state plus launch-time capture of the byte and configuration.
  always_comb begin
    state_d    = state_q;
    transmit_d = 1'b0;
    dr_d       = dr_q;
    cfg_d      = cfg_q;
    if (state_q == IDLE) begin
      if (launch) begin
        state_d    = WAIT;
        transmit_d = 1'b1;
        dr_d       = buf_head;
        cfg_d      = cfg_in;
      end
    end else begin
      if (done_i) begin
        state_d = IDLE;
      end
    end
  end

  // Sticky flags: launches and clear strobes drop them, a set always wins.
  always_comb begin
    tc_d  = tc_q;
    ovf_d = ovf_q;
    if (launch || tc_clr_i) begin
      tc_d = 1'b0;
    end
    if (tc_set) begin
      tc_d = 1'b1;
    end
    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  // Controller registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      transmit_q <= 1'b0;
      dr_q       <= '0;
      cfg_q      <= '0;
      tc_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      transmit_q <= transmit_d;
      dr_q       <= dr_d;
      cfg_q      <= cfg_d;
      tc_q       <= tc_d;
      ovf_q      <= ovf_d;
    end
  end

  assign cr_acc_incr_o = cfg_q.acc_incr;
  assign cr_ds_o       = cfg_q.ds;
  assign cr_p_o        = cfg_q.p;
  assign cr_s_o        = cfg_q.s;
  assign transmit_o    = transmit_q;
  assign dr_o          = dr_q;
  assign txe_o         = buf_empty;
  assign txf_o         = buf_full;
  assign level_o       = buf_level;
  assign busy_o        = (state_q == WAIT);
  assign tc_o          = tc_q;
  assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_tx_controller.sv
// Bench for tx_controller. Stimulus pushes expected launches into a queue;
// a monitor pops and compares on every transmit pulse. A small frontend
// model answers each launch with done_i a few cycles later. Expected
// buffer capacity follows DWBUART_TX_FIFO_EN.
module tb_tx_controller;

  localparam int FIFO_DEPTH = 8;
`ifdef DWBUART_TX_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  localparam int DEPTH = 1;
`endif
  localparam int LW        = $clog2(FIFO_DEPTH) + 1;
  localparam int FRAME_CYC = 4;
  localparam int TIMEOUT   = 200;

  logic          clk_i;
  logic          rst_ni;
  logic [15:0]   cr_acc_incr_i;
  logic          cr_ds_i;
  logic [1:0]    cr_p_i;
  logic          cr_s_i;
  logic          cr_te_i;
  logic          wr_i;
  logic [7:0]    wdata_i;
  logic          flush_i;
  logic          tc_clr_i;
  logic          ovf_clr_i;
  logic          done_i;
  logic [15:0]   cr_acc_incr_o;
  logic          cr_ds_o;
  logic [1:0]    cr_p_o;
  logic          cr_s_o;
  logic          transmit_o;
  logic [7:0]    dr_o;
  logic          txe_o;
  logic          txf_o;
  logic [LW-1:0] level_o;
  logic          busy_o;
  logic          tc_o;
  logic          ovf_o;

  typedef struct {
    logic [7:0]  data;
    logic [19:0] cfg;
    int          mode;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  int   testsRun;
  int   testsFailed;
  int   cycle;
  int   lastDoneCycle;
  bit   autoDone;
  bit   prevTx;

  tx_controller #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cr_acc_incr_i (cr_acc_incr_i),
    .cr_ds_i       (cr_ds_i),
    .cr_p_i        (cr_p_i),
    .cr_s_i        (cr_s_i),
    .cr_te_i       (cr_te_i),
    .wr_i          (wr_i),
    .wdata_i       (wdata_i),
    .flush_i       (flush_i),
    .tc_clr_i      (tc_clr_i),
    .ovf_clr_i     (ovf_clr_i),
    .done_i        (done_i),
    .cr_acc_incr_o (cr_acc_incr_o),
    .cr_ds_o       (cr_ds_o),
    .cr_p_o        (cr_p_o),
    .cr_s_o        (cr_s_o),
    .transmit_o    (transmit_o),
    .dr_o          (dr_o),
    .txe_o         (txe_o),
    .txf_o         (txf_o),
    .level_o       (level_o),
    .busy_o        (busy_o),
    .tc_o          (tc_o),
    .ovf_o         (ovf_o)
  );

  // Free-running clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Cycle counter used for launch-latency checks.
  always @(posedge clk_i) begin
    cycle <= cycle + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: timed out after %0d cycles", name, TIMEOUT);
  endtask

  task automatic pushExp(input logic [7:0] d, input int mode, input int cyc);
    exp_t e;
    e.data = d;
    e.cfg  = {cr_acc_incr_i, cr_ds_i, cr_p_i, cr_s_i};
    e.mode = mode;
    e.cyc  = cyc;
    expQ.push_back(e);
  endtask

  // One write strobe; called at a falling edge, returns one cycle later.
  task automatic applyStimulus(input logic [7:0] d);
    wr_i    = 1'b1;
    wdata_i = d;
    @(negedge clk_i);
    wr_i    = 1'b0;
  endtask

  task automatic pulseOvfClr();
    ovf_clr_i = 1'b1;
    @(negedge clk_i);
    ovf_clr_i = 1'b0;
  endtask

  task automatic waitBusy(input string name);
    int n = 0;
    while (busy_o !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= TIMEOUT) timeoutFail(name);
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    bit seen = 0;
    while (!seen && n < TIMEOUT) begin
      @(posedge clk_i);
      if (done_i === 1'b1) seen = 1;
      n++;
    end
    @(negedge clk_i);
    if (!seen) timeoutFail(name);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " transmit_o"}, 32'(transmit_o), 32'd0);
    checkOutput({tag, " dr_o"}, 32'(dr_o), 32'd0);
    checkOutput({tag, " cfg_o"}, 32'({cr_acc_incr_o, cr_ds_o, cr_p_o, cr_s_o}), 32'd0);
    checkOutput({tag, " txe_o"}, 32'(txe_o), 32'd1);
    checkOutput({tag, " txf_o"}, 32'(txf_o), 32'd0);
    checkOutput({tag, " level_o"}, 32'(level_o), 32'd0);
    checkOutput({tag, " busy_o"}, 32'(busy_o), 32'd0);
    checkOutput({tag, " tc_o"}, 32'(tc_o), 32'd0);
    checkOutput({tag, " ovf_o"}, 32'(ovf_o), 32'd0);
  endtask

  // Frontend model: answers each launch with a one-cycle done pulse.
  initial begin
    done_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (transmit_o === 1'b1 && autoDone) begin
        repeat (FRAME_CYC) @(negedge clk_i);
        if (autoDone) begin
          done_i        = 1'b1;
          lastDoneCycle = cycle;
          @(negedge clk_i);
          done_i = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: every transmit pulse must match the queue head.
  initial begin
    exp_t e;
    prevTx = 1'b0;
    forever begin
      @(negedge clk_i);
      if (transmit_o === 1'b1) begin
        checkOutput("single-cycle transmit", 32'(prevTx), 32'd0);
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected launch: dr_o 0x%0h with no byte pending", dr_o);
        end else begin
          e = expQ.pop_front();
          checkOutput("launch dr_o", 32'(dr_o), 32'(e.data));
          checkOutput("launch cfg", 32'({cr_acc_incr_o, cr_ds_o, cr_p_o, cr_s_o}), 32'(e.cfg));
          if (e.mode == 1) checkOutput("write-to-launch cycle", 32'(cycle), 32'(e.cyc));
          else if (e.mode == 2) checkOutput("done-to-launch cycle", 32'(cycle), 32'(lastDoneCycle + 2));
        end
      end
      prevTx = transmit_o;
    end
  end

  // Watchdog against a stuck run.
  initial begin
    repeat (20000) @(posedge clk_i);
    testsFailed++;
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int nFrames;
    cycle         = 0;
    lastDoneCycle = 0;
    testsRun      = 0;
    testsFailed   = 0;
    autoDone      = 1;
    rst_ni        = 1'b1;
    cr_acc_incr_i = 16'h0000;
    cr_ds_i       = 1'b0;
    cr_p_i        = 2'b00;
    cr_s_i        = 1'b0;
    cr_te_i       = 1'b0;
    wr_i          = 1'b0;
    wdata_i       = 8'h00;
    flush_i       = 1'b0;
    tc_clr_i      = 1'b0;
    ovf_clr_i     = 1'b0;
    #1 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    checkResetValues("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);

    cr_acc_incr_i = 16'h1234;
    cr_ds_i       = 1'b1;
    cr_p_i        = 2'b01;
    cr_s_i        = 1'b0;
    cr_te_i       = 1'b1;

    $display("[TB] single byte");
    pushExp(8'h55, 1, cycle + 2);
    applyStimulus(8'h55);
    checkOutput("level after write", 32'(level_o), 32'd1);
    checkOutput("txe after write", 32'(txe_o), 32'd0);
    waitDone("single done");
    checkOutput("single tc", 32'(tc_o), 32'd1);
    checkOutput("single busy", 32'(busy_o), 32'd0);
    checkOutput("single txe", 32'(txe_o), 32'd1);

    $display("[TB] back-to-back");
    pushExp(8'hA1, 1, cycle + 2);
    applyStimulus(8'hA1);
    pushExp(8'hB2, 2, 0);
    applyStimulus(8'hB2);
    if (DEPTH >= 2) pushExp(8'hC3, 2, 0);
    applyStimulus(8'hC3);
    nFrames = (DEPTH >= 2) ? 3 : 2;
    for (int i = 0; i < nFrames; i++) begin
      waitDone("b2b done");
      checkOutput("b2b tc after done", 32'(tc_o), 32'(i == nFrames - 1));
    end
    checkOutput("b2b ovf", 32'(ovf_o), 32'(DEPTH == 1));
    pulseOvfClr();
    checkOutput("ovf clear", 32'(ovf_o), 32'd0);

    $display("[TB] overflow");
    cr_te_i = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) pushExp(8'h10 + 8'(i), (i == 0) ? 0 : 2, 0);
      applyStimulus(8'h10 + 8'(i));
    end
    checkOutput("ovf level", 32'(level_o), 32'(DEPTH));
    checkOutput("ovf txf", 32'(txf_o), 32'd1);
    checkOutput("ovf txe", 32'(txe_o), 32'd0);
    checkOutput("ovf flag", 32'(ovf_o), 32'd1);
    cr_te_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) waitDone("ovf drain done");
    checkOutput("ovf drain tc", 32'(tc_o), 32'd1);
    checkOutput("ovf drain level", 32'(level_o), 32'd0);
    pulseOvfClr();

    $display("[TB] flag set/clear priority and flush with write");
    tc_clr_i = 1'b1;
    @(negedge clk_i);
    tc_clr_i = 1'b0;
    checkOutput("tc clear", 32'(tc_o), 32'd0);
    cr_te_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) applyStimulus(8'h40 + 8'(i));
    ovf_clr_i = 1'b1;
    applyStimulus(8'h4F);
    ovf_clr_i = 1'b0;
    checkOutput("ovf set beats clear", 32'(ovf_o), 32'd1);
    pulseOvfClr();
    flush_i = 1'b1;
    applyStimulus(8'h5A);
    flush_i = 1'b0;
    checkOutput("flush+write level", 32'(level_o), 32'd0);
    checkOutput("flush+write ovf", 32'(ovf_o), 32'd0);
    cr_te_i = 1'b1;

    $display("[TB] snapshot");
    pushExp(8'h66, 1, cycle + 2);
    applyStimulus(8'h66);
    waitBusy("snapshot busy");
    cr_ds_i = 1'b0;
    cr_p_i  = 2'b10;
    @(negedge clk_i);
    checkOutput("snapshot ds held", 32'(cr_ds_o), 32'd1);
    checkOutput("snapshot p held", 32'(cr_p_o), 32'd1);
    pushExp(8'h77, 2, 0);
    applyStimulus(8'h77);
    checkOutput("snapshot ds still held", 32'(cr_ds_o), 32'd1);
    waitDone("snapshot done 1");
    waitDone("snapshot done 2");
    checkOutput("snapshot ds new", 32'(cr_ds_o), 32'd0);
    checkOutput("snapshot p new", 32'(cr_p_o), 32'd2);

    $display("[TB] flush mid-frame");
    cr_te_i = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(8'h80 + 8'(i));
    pushExp(8'h80, 0, 0);
    cr_te_i = 1'b1;
    waitBusy("flush busy");
    checkOutput("flush pre level", 32'(level_o), 32'(((DEPTH < 5) ? DEPTH : 5) - 1));
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    checkOutput("flush level", 32'(level_o), 32'd0);
    checkOutput("flush txe", 32'(txe_o), 32'd1);
    checkOutput("flush busy kept", 32'(busy_o), 32'd1);
    waitDone("flush done");
    checkOutput("flush tc", 32'(tc_o), 32'd1);
    repeat (10) @(negedge clk_i);
    checkOutput("flush no relaunch", 32'(busy_o), 32'd0);
    pulseOvfClr();

    $display("[TB] async reset mid-frame");
    cr_te_i = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(8'h90 + 8'(i));
    pushExp(8'h90, 0, 0);
    cr_te_i = 1'b1;
    waitBusy("reset busy");
    checkOutput("reset pre level", 32'(level_o), 32'(((DEPTH < 4) ? DEPTH : 4) - 1));
    autoDone = 0;
    #2 rst_ni = 1'b0;
    #1 checkResetValues("async reset");
    @(negedge clk_i);
    rst_ni   = 1'b1;
    autoDone = 1;
    repeat (12) @(negedge clk_i);
    checkOutput("post-reset busy", 32'(busy_o), 32'd0);
    checkOutput("post-reset level", 32'(level_o), 32'd0);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
